// File: rtl/mdu_div_wb_if.sv
// Divider request/writeback bundle between the core and the iterative divider.
// The master side issues requests; the slave side is the divider itself.
interface mdu_div_wb_if #(
  parameter int WAD = 5,
  parameter int WD  = 32
);
  logic           start;
  logic [1:0]     op;
  logic [WD-1:0]  rs1_val;
  logic [WD-1:0]  rs2_val;
  logic [WAD-1:0] rd_addr;
  logic           kill;
  logic           busy;
  logic           stall;
  logic           done;
  logic           wb_en;
  logic [WAD-1:0] wb_addr;
  logic [WD-1:0]  wb_data;

  modport master (
    output start, op, rs1_val, rs2_val, rd_addr, kill,
    input  busy, stall, done, wb_en, wb_addr, wb_data
  );

  modport slave (
    input  start, op, rs1_val, rs2_val, rd_addr, kill,
    output busy, stall, done, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/mdu_div_wb.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU that
// drives a single register-file write when the result is ready.
module mdu_div_wb #(
  parameter int WAD = 5,
  parameter int WD  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mdu_div_wb_if.slave  bus
);

  localparam int CW = $clog2(WD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [WD-1:0] neg(input logic [WD-1:0] v);
    return ~v + {{(WD-1){1'b0}}, 1'b1};
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [WAD-1:0] rd_q, rd_d;
  logic [WD-1:0]  quo_q, quo_d;
  logic [WD-1:0]  dvs_q, dvs_d;
  logic [WD-1:0]  rem_q, rem_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           wb_en_q, wb_en_d;
  logic [WAD-1:0] wb_addr_q, wb_addr_d;
  logic [WD-1:0]  wb_data_q, wb_data_d;

  logic           is_signed_s, sign1_s, sign2_s, div0_s, ovf_s;
  logic [WD-1:0]  abs1_s, abs2_s, q_fix_s, r_fix_s;
  logic [WD:0]    rem_sh_s, diff_s;

  // Operand conditioning and the single shift-subtract step datapath.
  always_comb begin
    is_signed_s = ~bus.op[0];
    sign1_s     = is_signed_s & bus.rs1_val[WD-1];
    sign2_s     = is_signed_s & bus.rs2_val[WD-1];
    abs1_s      = sign1_s ? neg(bus.rs1_val) : bus.rs1_val;
    abs2_s      = sign2_s ? neg(bus.rs2_val) : bus.rs2_val;
    div0_s      = (bus.rs2_val == {WD{1'b0}});
    ovf_s       = is_signed_s & (bus.rs1_val == {1'b1, {(WD-1){1'b0}}}) &
                  (bus.rs2_val == {WD{1'b1}});
    // The partial remainder never exceeds the divisor, so bit WD of the
    // difference is a clean borrow flag.
    rem_sh_s    = {rem_q, quo_q[WD-1]};
    diff_s      = rem_sh_s - {1'b0, dvs_q};
    q_fix_s     = qneg_q ? neg(quo_q) : quo_q;
    r_fix_s     = rneg_q ? neg(rem_q) : rem_q;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d = bus.op;
          rd_d = bus.rd_addr;
          if (div0_s) begin
            wb_data_d = bus.op[1] ? bus.rs1_val : {WD{1'b1}};
            wb_addr_d = bus.rd_addr;
            state_d   = S_DONE;
          end else if (ovf_s) begin
            wb_data_d = bus.op[1] ? {WD{1'b0}} : bus.rs1_val;
            wb_addr_d = bus.rd_addr;
            state_d   = S_DONE;
          end else begin
            quo_d   = abs1_s;
            dvs_d   = abs2_s;
            rem_d   = {WD{1'b0}};
            cnt_d   = {CW{1'b0}};
            qneg_d  = sign1_s ^ sign2_s;
            rneg_d  = sign1_s;
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          rem_d = diff_s[WD] ? rem_sh_s[WD-1:0] : diff_s[WD-1:0];
          quo_d = {quo_q[WD-2:0], ~diff_s[WD]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WD-1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          wb_data_d = op_q[1] ? r_fix_s : q_fix_s;
          wb_addr_d = rd_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    wb_en_d = done_d & (wb_addr_d != {WAD{1'b0}});
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      op_q      <= 2'b00;
      rd_q      <= {WAD{1'b0}};
      quo_q     <= {WD{1'b0}};
      dvs_q     <= {WD{1'b0}};
      rem_q     <= {WD{1'b0}};
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= {WAD{1'b0}};
      wb_data_q <= {WD{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.stall   = busy_q | (bus.start & (state_q == S_IDLE));
  assign bus.done    = done_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

endmodule

// File: tb/tb_mdu_div_wb.sv
// Directed and back-to-back checks for mdu_div_wb against hand-computed
// results and a native-arithmetic reference.
module tb_mdu_div_wb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  mdu_div_wb_if #(.WAD(5), .WD(32)) bus ();
  mdu_div_wb #(.WAD(5), .WD(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    case (op)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge with the divider idle; scrambles inputs mid-flight.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int n;
    bus.op = op; bus.rs1_val = a; bus.rs2_val = b; bus.rd_addr = rd; bus.start = 1'b1;
    #1 chk({tag, "_stall"}, 32'(bus.stall), 32'd1);
    @(negedge clk);
    bus.start = 1'b0; bus.rs1_val = $urandom; bus.rs2_val = $urandom;
    bus.op = ~op; bus.rd_addr = ~rd;
    n = 1;
    while (!bus.done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_wben"}, 32'(bus.wb_en), 32'(rd != 5'd0));
    chk({tag, "_addr"}, 32'(bus.wb_addr), 32'(rd));
    chk({tag, "_data"}, bus.wb_data, exp);
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    chk({tag, "_wben_clr"}, 32'(bus.wb_en), 32'd0);
    chk({tag, "_busy_clr"}, 32'(bus.busy), 32'd0);
    chk({tag, "_data_hold"}, bus.wb_data, exp);
  endtask

  initial begin
    int hits;
    int n;
    logic [1:0]  op;
    logic [31:0] a, b, exp;
    logic [4:0]  rd;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs1_val = 32'd0; bus.rs2_val = 32'd0;
    bus.rd_addr = 5'd0; bus.kill = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wben", 32'(bus.wb_en), 32'd0);
    chk("rst_addr", 32'(bus.wb_addr), 32'd0);
    chk("rst_data", bus.wb_data, 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_100_7",   2'b00, 32'd100,        32'd7,          5'd5,  32'd14,         34);
    run_op("rem_100_7",   2'b10, 32'd100,        32'd7,          5'd5,  32'd2,          34);
    run_op("div_m100_7",  2'b00, 32'hFFFF_FF9C,  32'd7,          5'd6,  32'hFFFF_FFF2,  34);
    run_op("rem_m100_7",  2'b10, 32'hFFFF_FF9C,  32'd7,          5'd7,  32'hFFFF_FFFE,  34);
    run_op("divu_max_2",  2'b01, 32'hFFFF_FFFF,  32'd2,          5'd8,  32'h7FFF_FFFF,  34);
    run_op("remu_max_2",  2'b11, 32'hFFFF_FFFF,  32'd2,          5'd9,  32'd1,          34);
    run_op("div_7_m2",    2'b00, 32'd7,          32'hFFFF_FFFE,  5'd10, 32'hFFFF_FFFD,  34);
    run_op("rem_7_m2",    2'b10, 32'd7,          32'hFFFF_FFFE,  5'd11, 32'd1,          34);
    run_op("divu_min_m1", 2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          34);
    run_op("remu_min_m1", 2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  34);
    run_op("divu_5_0",    2'b01, 32'd5,          32'd0,          5'd14, 32'hFFFF_FFFF,  1);
    run_op("rem_5_0",     2'b10, 32'd5,          32'd0,          5'd15, 32'd5,          1);
    run_op("div_ovf",     2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000,  1);
    run_op("rem_ovf",     2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'd0,          1);

    // Ignored restart at cycle 3, abort at cycle 20.
    bus.op = 2'b01; bus.rs1_val = 32'd100; bus.rs2_val = 32'd7; bus.rd_addr = 5'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hits = 0;
    for (int c = 1; c < 45; c++) begin
      bus.start = (c == 3);
      bus.kill  = (c == 20);
      @(negedge clk);
      if (bus.done || bus.wb_en) hits++;
    end
    bus.start = 1'b0; bus.kill = 1'b0;
    chk("kill_no_wb", 32'(hits), 32'd0);
    chk("kill_idle", 32'(bus.busy), 32'd0);
    run_op("div_9_3_r0", 2'b00, 32'd9, 32'd3, 5'd0, 32'd3, 34);

    // Asynchronous reset in the middle of an iteration.
    bus.op = 2'b01; bus.rs1_val = 32'd100; bus.rs2_val = 32'd7; bus.rd_addr = 5'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_wben", 32'(bus.wb_en), 32'd0);
    chk("mrst_addr", 32'(bus.wb_addr), 32'd0);
    chk("mrst_data", bus.wb_data, 32'd0);
    hits = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.wb_en || bus.done || bus.busy) hits++;
    end
    chk("mrst_quiet", 32'(hits), 32'd0);

    // start held high: one IDLE cycle between operations, results vs reference.
    bus.start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      rd = 5'($urandom_range(0, 31));
      exp = ref_div(op, a, b);
      bus.op = op; bus.rs1_val = a; bus.rs2_val = b; bus.rd_addr = rd;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.done && n < 60);
      chk("b2b_lat", 32'(n),
          32'(((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34));
      chk("b2b_data", bus.wb_data, exp);
      chk("b2b_wben", 32'(bus.wb_en), 32'(rd != 5'd0));
      @(negedge clk);
      chk("b2b_idle", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
